// File: rtl/mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// mem_bridge_pkg
// Shared definitions for the core-to-memory request bridge:
//   - bridge_state_e   : 2-bit FSM state encoding (IDLE, WAIT, DONE)
//   - DEFAULT_TIMEOUT  : default number of WAIT cycles before an access aborts
//   - DEFAULT_ERR_WORD : default read data returned when an access times out
//   - select_be_byte() : big-endian byte lane pick used by byte reads
// -----------------------------------------------------------------------------
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } bridge_state_e;

    localparam int unsigned DEFAULT_TIMEOUT  = 32'd255;
    localparam logic [31:0] DEFAULT_ERR_WORD = 32'hDEAD_BEEF;

    // Byte offset 0 addresses the most significant byte (big-endian core).
    function automatic logic [7:0] select_be_byte(input logic [31:0] word,
                                                  input logic [1:0]  sel);
        logic [7:0] b;
        case (sel)
            2'b00:   b = word[31:24];
            2'b01:   b = word[23:16];
            2'b10:   b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage : mem_bridge_pkg

// File: rtl/mem_req_bridge_if.sv
// -----------------------------------------------------------------------------
// mem_req_bridge_if
// Request/acknowledge memory bus between the bridge and unified memory.
//   mem_req   : request, held high until acknowledged or aborted
//   mem_we    : 1 = write, 0 = read
//   mem_adr   : word-aligned byte address
//   mem_wdata : write data
//   mem_ack   : memory completes the current request
//   mem_rdata : read data, valid together with mem_ack
// Modports: master = bridge side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_req_bridge_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_adr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_adr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface : mem_req_bridge_if

// File: rtl/bus_timeout_cnt.sv
// -----------------------------------------------------------------------------
// bus_timeout_cnt
// Clear/enable up-counter with terminal-count flag, used to bound how long
// the bridge waits for a memory acknowledge.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : load zero (has priority over en)
//   en         : increment by one
//   tc         : count equals MAX_COUNT
// Width is just enough to hold MAX_COUNT; the owner stops enabling once tc
// is seen, so the counter never wraps in normal use.
// -----------------------------------------------------------------------------
module bus_timeout_cnt #(
    parameter int unsigned MAX_COUNT = 32'd255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned          CNT_W  = $clog2(MAX_COUNT + 32'd1);
    localparam logic [CNT_W-1:0]     TC_VAL = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0]     ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule : bus_timeout_cnt

// File: rtl/mem_req_bridge.sv
// -----------------------------------------------------------------------------
// mem_req_bridge
// Bridges the multicycle core's single-cycle memory port onto a
// variable-latency req/ack memory. Each core access is captured, held on the
// bus until acknowledged (or aborted by timeout), the core is stalled
// meanwhile, and read data is returned from a register.
//
// Parameters:
//   TIMEOUT  : WAIT cycles without ack before abort (1..65535)
//   ERR_WORD : read data returned for an aborted access
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   cpu_req       : core wants memory this cycle (held high while stalled)
//   cpu_adr       : byte address
//   cpu_wdata     : store data
//   cpu_memwrite  : 1 = write, 0 = read
//   cpu_lbu       : byte read select (only with MEM_BRIDGE_BYTE_EN)
//   cpu_rdata     : read data, valid in DONE (stall low)
//   stall         : freezes the core
//   bus_err       : sticky timeout flag, cleared only by reset
//   mem           : memory bus (mem_req_bridge_if.master)
// Build option:
//   MEM_BRIDGE_BYTE_EN : adds cpu_lbu; byte reads return the addressed
//                        big-endian byte zero-extended.
// -----------------------------------------------------------------------------
module mem_req_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT,
    parameter logic [31:0] ERR_WORD = DEFAULT_ERR_WORD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic [31:0]             cpu_adr,
    input  logic [31:0]             cpu_wdata,
    input  logic                    cpu_memwrite,
`ifdef MEM_BRIDGE_BYTE_EN
    input  logic                    cpu_lbu,
`endif
    output logic [31:0]             cpu_rdata,
    output logic                    stall,
    output logic                    bus_err,
    mem_req_bridge_if.master        mem
);

    bridge_state_e state_q, state_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [31:0]   mem_adr_q,   mem_adr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   rdata_q,     rdata_d;
    logic          bus_err_q,   bus_err_d;
`ifdef MEM_BRIDGE_BYTE_EN
    logic          lbu_q,       lbu_d;
    logic [1:0]    byte_sel_q,  byte_sel_d;
`endif

    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_tc;

    bus_timeout_cnt #(
        .MAX_COUNT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // FSM next state, bus payload capture, read-data/error update.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;
`ifdef MEM_BRIDGE_BYTE_EN
        lbu_d       = lbu_q;
        byte_sel_d  = byte_sel_q;
`endif
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    // Only the latched copy is used from here on; the core's
                    // live inputs are don't-care until the next capture.
                    mem_req_d   = 1'b1;
                    mem_we_d    = cpu_memwrite;
                    mem_adr_d   = {cpu_adr[31:2], 2'b00};
                    mem_wdata_d = cpu_wdata;
`ifdef MEM_BRIDGE_BYTE_EN
                    lbu_d       = cpu_lbu;
                    byte_sel_d  = cpu_adr[1:0];
`endif
                    cnt_clr     = 1'b1;
                    state_d     = ST_WAIT;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_WAIT: begin
                // Ack is checked first so an ack on the terminal-count cycle
                // completes normally instead of aborting.
                if (mem.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = mem.mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d   = ST_DONE;
                end else if (cnt_tc) begin
                    mem_req_d = 1'b0;
                    rdata_d   = ERR_WORD;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_en    = 1'b1;
                    state_d   = ST_WAIT;
                end
            end

            ST_DONE: begin
                // One unstalled cycle for the core; cpu_req here belongs to
                // the access just finished, so it is never a new request.
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and bus/data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            bus_err_q   <= 1'b0;
`ifdef MEM_BRIDGE_BYTE_EN
            lbu_q       <= 1'b0;
            byte_sel_q  <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
`ifdef MEM_BRIDGE_BYTE_EN
            lbu_q       <= lbu_d;
            byte_sel_q  <= byte_sel_d;
`endif
        end
    end

    // Read data presented to the core.
`ifdef MEM_BRIDGE_BYTE_EN
    always_comb begin
        if (lbu_q) begin
            cpu_rdata = {24'h00_0000, select_be_byte(rdata_q, byte_sel_q)};
        end else begin
            cpu_rdata = rdata_q;
        end
    end
`else
    assign cpu_rdata = rdata_q;

    // Byte offset has no meaning without byte reads.
    logic unused_adr_bits;
    assign unused_adr_bits = ^cpu_adr[1:0];
`endif

    // Stall must be combinational so the core freezes in the capture cycle.
    assign stall         = cpu_req & (state_q != ST_DONE);
    assign bus_err       = bus_err_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_adr   = mem_adr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule : mem_req_bridge

// File: tb/tb_mem_req_bridge.sv
// -----------------------------------------------------------------------------
// tb_mem_req_bridge
// Directed plus randomized accesses against a transaction-level model of the
// bridge: each access is described by its payload and by the cycle on which
// memory acknowledges (or never does), and the model predicts bus contents,
// stall duration, returned data and the sticky error flag.
// -----------------------------------------------------------------------------
module tb_mem_req_bridge;
    import mem_bridge_pkg::*;

    localparam int unsigned TB_TIMEOUT = 32'd4;
    localparam logic [31:0] TB_ERR     = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic        cpu_memwrite;
    logic        cpu_lbu;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        bus_err;

    mem_req_bridge_if mem_if ();

    mem_req_bridge #(
        .TIMEOUT  (TB_TIMEOUT),
        .ERR_WORD (TB_ERR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_adr      (cpu_adr),
        .cpu_wdata    (cpu_wdata),
        .cpu_memwrite (cpu_memwrite),
`ifdef MEM_BRIDGE_BYTE_EN
        .cpu_lbu      (cpu_lbu),
`endif
        .cpu_rdata    (cpu_rdata),
        .stall        (stall),
        .bus_err      (bus_err),
        .mem          (mem_if.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: last word returned, sticky error, and how it is presented.
    logic [31:0] m_word = 32'h0;
    logic        m_err  = 1'b0;
    logic        m_lbu  = 1'b0;
    logic [1:0]  m_off  = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [31:0] sh;
        sh = m_word >> (8 * (3 - int'(m_off)));
        return m_lbu ? (sh & 32'h0000_00FF) : m_word;
    endfunction

    // One core access, starting at a negedge in IDLE. k = wait cycles before
    // ack; k > TB_TIMEOUT means memory never answers.
    task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                       input logic lbu, input int k, input logic [31:0] rd);
        bit acked;
        int n_wait;
        acked  = (k <= int'(TB_TIMEOUT));
        n_wait = acked ? k : int'(TB_TIMEOUT);
        cpu_req      = 1'b1;
        cpu_adr      = adr;
        cpu_wdata    = wd;
        cpu_memwrite = we;
        cpu_lbu      = lbu;
        mem_if.mem_ack   = 1'($urandom_range(0, 1));
        mem_if.mem_rdata = $urandom;
        #1;
        check("idle_stall", {31'h0, stall}, 32'd1);
        @(negedge clk);
        for (int j = 0; j <= n_wait; j++) begin
            check("wait_req",   {31'h0, mem_if.mem_req}, 32'd1);
            check("wait_stall", {31'h0, stall},          32'd1);
            check("wait_adr",   mem_if.mem_adr,          {adr[31:2], 2'b00});
            check("wait_we",    {31'h0, mem_if.mem_we},  {31'h0, we});
            check("wait_wdata", mem_if.mem_wdata,        wd);
            cpu_adr      = $urandom;
            cpu_wdata    = $urandom;
            cpu_memwrite = 1'($urandom_range(0, 1));
            cpu_lbu      = 1'($urandom_range(0, 1));
            mem_if.mem_ack   = (acked && j == k);
            mem_if.mem_rdata = (acked && j == k) ? rd : $urandom;
            @(negedge clk);
        end
        if (acked) begin
            if (!we) m_word = rd;
        end else begin
            m_word = TB_ERR;
            m_err  = 1'b1;
        end
`ifdef MEM_BRIDGE_BYTE_EN
        m_lbu = lbu;
        m_off = adr[1:0];
`else
        m_lbu = 1'b0;
`endif
        mem_if.mem_ack = 1'($urandom_range(0, 1));
        check("done_stall", {31'h0, stall},          32'd0);
        check("done_req",   {31'h0, mem_if.mem_req}, 32'd0);
        check("done_rdata", cpu_rdata,               exp_rdata());
        check("done_err",   {31'h0, bus_err},        {31'h0, m_err});
        @(negedge clk);
        // cpu_req stayed high through DONE; that must not have started a new access
        check("post_done_req", {31'h0, mem_if.mem_req}, 32'd0);
        mem_if.mem_ack = 1'b0;
    endtask

    task automatic idle_cycle();
        cpu_req = 1'b0;
        mem_if.mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_req", {31'h0, mem_if.mem_req}, 32'd0);
        mem_if.mem_ack = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        cpu_req          = 1'b0;
        cpu_adr          = 32'h0;
        cpu_wdata        = 32'h0;
        cpu_memwrite     = 1'b0;
        cpu_lbu          = 1'b0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_req",   {31'h0, mem_if.mem_req}, 32'd0);
        check("rst_we",    {31'h0, mem_if.mem_we},  32'd0);
        check("rst_adr",   mem_if.mem_adr,          32'd0);
        check("rst_wdata", mem_if.mem_wdata,        32'd0);
        check("rst_rdata", cpu_rdata,               32'd0);
        check("rst_err",   {31'h0, bus_err},        32'd0);
        check("rst_stall0", {31'h0, stall},         32'd0);
        cpu_req = 1'b1;
        #1;
        check("rst_stall1", {31'h0, stall},         32'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle_cycle();

        // Zero-wait read
        txn(32'h0000_0010, 1'b0, 32'h0, 1'b0, 0, 32'h1234_5678);
        idle_cycle();
        // Write with three wait cycles; read data must persist
        txn(32'h0000_0044, 1'b1, 32'hCAFE_F00D, 1'b0, 3, 32'h5555_AAAA);
        // Ack on the terminal-count cycle, back-to-back with the write
        txn(32'h0000_0100, 1'b0, 32'h0, 1'b0, int'(TB_TIMEOUT), 32'h0BAD_F00D);
        check("tc_ack_no_err", {31'h0, bus_err}, 32'd0);
        // No ack at all -> timeout
        txn(32'h0000_0200, 1'b0, 32'h0, 1'b0, int'(TB_TIMEOUT) + 1, 32'h0);
        idle_cycle();
        // Good access afterwards, error stays set
        txn(32'h0000_0204, 1'b0, 32'h0, 1'b0, 1, 32'h0102_0304);

`ifdef MEM_BRIDGE_BYTE_EN
        txn(32'h0000_1002, 1'b0, 32'h0, 1'b1, 0, 32'hAABB_CCDD);
        check("lbu_cc", cpu_rdata, 32'h0000_00CC);
        for (int off = 0; off < 4; off++) begin
            txn(32'h0000_2000 | 32'(off), 1'b0, 32'h0, 1'b1, off, $urandom);
        end
`endif

        // Randomized accesses
        for (int t = 0; t < 30; t++) begin
            txn($urandom, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, TB_TIMEOUT + 2)), $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        // Reset in the middle of WAIT
        cpu_req      = 1'b1;
        cpu_adr      = 32'h0000_0300;
        cpu_wdata    = 32'h7777_8888;
        cpu_memwrite = 1'b1;
        mem_if.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_wait_req", {31'h0, mem_if.mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_req",   {31'h0, mem_if.mem_req}, 32'd0);
        check("arst_we",    {31'h0, mem_if.mem_we},  32'd0);
        check("arst_adr",   mem_if.mem_adr,          32'd0);
        check("arst_wdata", mem_if.mem_wdata,        32'd0);
        check("arst_rdata", cpu_rdata,               32'd0);
        check("arst_err",   {31'h0, bus_err},        32'd0);
        check("arst_stall", {31'h0, stall},          32'd1);
        m_word = 32'h0;
        m_err  = 1'b0;
        m_lbu  = 1'b0;
        m_off  = 2'b00;
        @(negedge clk);
        reset   = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("post_rst_stall", {31'h0, stall}, 32'd0);
        idle_cycle();
        check("discarded_req", {31'h0, mem_if.mem_req}, 32'd0);

        // A few accesses after reset
        for (int t = 0; t < 6; t++) begin
            txn($urandom, 1'($urandom_range(0, 1)), $urandom, 1'b0,
                int'($urandom_range(0, TB_TIMEOUT)), $urandom);
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_req_bridge
